reg_seg_display: RTL and testbench

//  Debug display stage downstream of the single-cycle CPU top.

---
 rtl/reg_seg_display_if.sv | 8 +
 rtl/reg_seg_display.sv | 132 +++++++++++++
 tb/tb_reg_seg_display.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_seg_display_if.sv
// Register-inspection port between the debug display stage (master) and the CPU register file (slave).
interface reg_seg_display_if;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    modport master (output reg_sel, input reg_data);
    modport slave  (input reg_sel, output reg_data);
endinterface

// File: rtl/reg_seg_display.sv
// Steps through the CPU registers and shows the selected one as 8 hex digits on a multiplexed 7-seg display.
// Optional DISP_BLANK_LEAD_EN blanks leading zero digits (digit 0 always shown).
module reg_seg_display #(
    parameter int SCAN_DIV = 50000,
    parameter int STEP_DIV = 50000000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sw_auto,
    input  logic                      sw_hold,
    input  logic                      btn_next,
    reg_seg_display_if.master         dbg,
    output logic [7:0]                an,
    output logic [7:0]                seg
);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        digit_q, digit_d;
    logic [31:0]       disp_q, disp_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [4:0]        reg_sel_q, reg_sel_d;
    logic              btn_sync1_q, btn_sync1_d;
    logic              btn_sync2_q, btn_sync2_d;
    logic              btn_prev_q, btn_prev_d;
    logic [7:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic scan_wrap;
    logic frame_end;
    logic step_en;
    logic auto_pulse;
    logic btn_pulse;
    logic [3:0]  nibble;
    logic [31:0] lead_bits;
    logic        blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        frame_end  = scan_wrap && (digit_q == 3'd7);
        step_en    = sw_auto && !sw_hold;
        auto_pulse = step_en && (step_cnt_q == STEP_LAST);
        btn_pulse  = btn_sync2_q && !btn_prev_q;

        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_d    = scan_wrap ? digit_q + 3'd1 : digit_q;

        // Capture uses the register currently selected, so a step on the boundary clock shows next frame.
        disp_d = (frame_end && !sw_hold) ? dbg.reg_data : disp_q;

        if (!step_en) begin
            step_cnt_d = '0;
        end else if (auto_pulse) begin
            step_cnt_d = '0;
        end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
        end

        // Button pulses during hold are dropped, never deferred.
        reg_sel_d = ((auto_pulse || btn_pulse) && !sw_hold) ? reg_sel_q + 5'd1 : reg_sel_q;

        btn_sync1_d = btn_next;
        btn_sync2_d = btn_sync1_q;
        btn_prev_d  = btn_sync2_q;
    end

    always_comb begin
        nibble    = disp_q[{digit_q, 2'b00} +: 4];
        lead_bits = disp_q >> {digit_q, 2'b00};
`ifdef DISP_BLANK_LEAD_EN
        blank = (digit_q != 3'd0) && (lead_bits == 32'd0);
`else
        blank = 1'b0;
`endif
        an_d  = ~(8'd1 << digit_q);
        seg_d = blank ? 8'hFF : {1'b1, hex7(nibble)};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scan_cnt_q  <= '0;
            digit_q     <= 3'd0;
            disp_q      <= 32'd0;
            step_cnt_q  <= '0;
            reg_sel_q   <= 5'd0;
            btn_sync1_q <= 1'b0;
            btn_sync2_q <= 1'b0;
            btn_prev_q  <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            disp_q      <= disp_d;
            step_cnt_q  <= step_cnt_d;
            reg_sel_q   <= reg_sel_d;
            btn_sync1_q <= btn_sync1_d;
            btn_sync2_q <= btn_sync2_d;
            btn_prev_q  <= btn_prev_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign dbg.reg_sel = reg_sel_q;
    assign an          = an_q;
    assign seg         = seg_q;
endmodule

// File: tb/tb_reg_seg_display.sv
// Randomized bench for reg_seg_display against a cycle-time model derived from elapsed clocks since reset.
module tb_reg_seg_display;
    localparam int SCAN_DIV = 4;
    localparam int STEP_DIV = 64;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sw_auto;
    logic       sw_hold;
    logic       btn_next;
    logic [7:0] an;
    logic [7:0] seg;
    logic [31:0] regs [32];

    reg_seg_display_if u_if ();
    assign u_if.reg_data = regs[u_if.reg_sel];

    reg_seg_display #(.SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .sw_auto  (sw_auto),
        .sw_hold  (sw_hold),
        .btn_next (btn_next),
        .dbg      (u_if.master),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: m_t = clocks since reset release, m_r = consecutive clocks of auto stepping enabled.
    int          m_t;
    int          m_r;
    logic [4:0]  m_sel;
    logic [31:0] m_disp;
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    logic        m_b1, m_b2, m_b3;
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg_of(input logic [31:0] v, input int d);
`ifdef DISP_BLANK_LEAD_EN
        if (d > 0 && (v >> (4 * d)) == 32'd0) return 8'hFF;
`endif
        return hex_tab[(v >> (4 * d)) & 32'hF];
    endfunction

    task automatic model_edge();
        int  d;
        logic auto_p, btn_p;
        if (!rstn) begin
            m_t = 0; m_r = 0; m_sel = 5'd0; m_disp = 32'd0;
            m_an = 8'hFF; m_seg = 8'hFF;
            m_b1 = 1'b0; m_b2 = 1'b0; m_b3 = 1'b0;
        end else begin
            d      = (m_t / SCAN_DIV) % 8;
            m_an   = ~(8'd1 << d);
            m_seg  = exp_seg_of(m_disp, d);
            if ((m_t % FRAME) == FRAME - 1 && !sw_hold) m_disp = regs[m_sel];
            auto_p = sw_auto && !sw_hold && (m_r % STEP_DIV == STEP_DIV - 1);
            m_r    = (sw_auto && !sw_hold) ? m_r + 1 : 0;
            btn_p  = m_b2 && !m_b3;
            m_b3 = m_b2; m_b2 = m_b1; m_b1 = btn_next;
            if ((auto_p || btn_p) && !sw_hold) m_sel = m_sel + 5'd1;
            m_t++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("an", {24'd0, an}, {24'd0, m_an});
        chk("seg", {24'd0, seg}, {24'd0, m_seg});
        chk("reg_sel", {27'd0, u_if.reg_sel}, {27'd0, m_sel});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [4:0] s;
    int         guard;

    initial begin
        rstn = 1'b0; sw_auto = 1'b0; sw_hold = 1'b0; btn_next = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h1234_ABCD;

        // Reset and first frames, register 0 value on display
        run(2);
        chk("reset_an", {24'd0, an}, 32'hFF);
        chk("reset_sel", {27'd0, u_if.reg_sel}, 32'd0);
        rstn = 1'b1;
        run(3 * FRAME);

        // Auto stepping through a full wrap
        sw_auto = 1'b1;
        s = m_sel;
        run(32 * STEP_DIV);
        chk("auto_wrap", {27'd0, u_if.reg_sel}, {27'd0, s});
        run(10);

        // Button: one increment per press, 3 clocks after the edge
        sw_auto = 1'b0;
        run(5);
        s = m_sel;
        btn_next = 1'b1;
        run(2);
        chk("btn_early", {27'd0, u_if.reg_sel}, {27'd0, s});
        run(1);
        chk("btn_step", {27'd0, u_if.reg_sel}, {27'd0, 5'(s + 5'd1)});
        run(7);
        btn_next = 1'b0;
        run(10);
        chk("btn_once", {27'd0, u_if.reg_sel}, {27'd0, 5'(s + 5'd1)});

        // Hold: button discarded, capture frozen while register contents change
        sw_hold = 1'b1;
        s = m_sel;
        btn_next = 1'b1;
        regs[s] = $urandom;
        run(10);
        btn_next = 1'b0;
        run(2 * FRAME);
        chk("hold_sel", {27'd0, u_if.reg_sel}, {27'd0, s});
        sw_hold = 1'b0;
        run(2 * FRAME);

        // Button pulse landing on the same clock as an auto pulse
        sw_auto = 1'b1;
        guard = 0;
        while ((m_r % STEP_DIV) != STEP_DIV - 3 && guard < 4 * STEP_DIV) begin
            cycle();
            guard++;
        end
        chk("align_budget", {31'd0, guard < 4 * STEP_DIV}, 32'd1);
        s = m_sel;
        btn_next = 1'b1;
        run(3);
        chk("simul_step", {27'd0, u_if.reg_sel}, {27'd0, 5'(s + 5'd1)});
        run(10);
        btn_next = 1'b0;
        run(13);

        // Reset mid-frame
        rstn = 1'b0;
        run(1);
        chk("midrst_seg", {24'd0, seg}, 32'hFF);
        chk("midrst_sel", {27'd0, u_if.reg_sel}, 32'd0);
        rstn = 1'b1;
        sw_auto = 1'b0;

        // All-zero register contents
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        run(3 * FRAME);
        regs[m_sel] = 32'h0000_00A5;
        run(3 * FRAME);

        // Random operation
        for (int i = 0; i < 32; i++) regs[i] = ($urandom_range(0, 3) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 2)  sw_auto = ~sw_auto;
            if ($urandom_range(0, 199) < 1) sw_hold = ~sw_hold;
            if ($urandom_range(0, 99) < 10) btn_next = ~btn_next;
            if ($urandom_range(0, 99) < 3)  regs[$urandom_range(0, 31)] = $urandom;
            rstn = ($urandom_range(0, 999) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
